// File: rtl/light_pkg.sv
`default_nettype none
// ============================================================================
// Module   : light_pkg
// Purpose  : Shared light codes, direction indices and sensor bit positions.
// Revision : 1.0
// ============================================================================
package light_pkg;

    localparam logic [2:0] LIGHT_STOP         = 3'b000;
    localparam logic [2:0] LIGHT_FORWARD_ONLY = 3'b001;
    localparam logic [2:0] LIGHT_LEFT_ONLY    = 3'b010;
    localparam logic [2:0] LIGHT_RIGHT_ONLY   = 3'b011;
    localparam logic [2:0] LIGHT_GO           = 3'b100;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    localparam int SENS_N = 6;
    localparam int SENS_E = 5;
    localparam int SENS_S = 4;
    localparam int SENS_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GREEN = 2'd1,
        ST_CLEAR = 2'd2
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/light_rr_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : light_rr_scheduler_if
// Purpose  : Sensor inputs and per-approach light outputs of one stop light.
// Revision : 1.0
// ============================================================================
interface light_rr_scheduler_if;
    logic [7:0]  sensor_light;
    logic [31:0] general_sensors;
    logic [2:0]  outN;
    logic [2:0]  outS;
    logic [2:0]  outE;
    logic [2:0]  outW;

    modport master (
        output sensor_light,
        output general_sensors,
        input  outN,
        input  outS,
        input  outE,
        input  outW
    );

    modport slave (
        input  sensor_light,
        input  general_sensors,
        output outN,
        output outS,
        output outE,
        output outW
    );
endinterface
`default_nettype wire

// File: rtl/light_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : light_rr_pick
// Purpose  : 4-way rotating priority encoder; scans last+1 .. last+4 (mod 4).
// Revision : 1.0
// ============================================================================
module light_rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       grant_valid,
    output logic [1:0] grant_dir
);
    logic [1:0] w_idx;

    // Scan from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        grant_valid = |req;
        grant_dir   = last;
        w_idx       = '0;
        for (int k = 4; k >= 1; k--) begin
            w_idx = last + 2'(k);
            if (req[w_idx]) begin
                grant_dir = w_idx;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/light_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : light_rr_scheduler
// Purpose  : Round-robin four-way stop light with min/max green and clearance.
// Revision : 1.0
// ============================================================================
module light_rr_scheduler
    import light_pkg::*;
#(
    parameter int MIN_GREEN    = 8,
    parameter int MAX_GREEN    = 32,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    light_rr_scheduler_if.slave  bus
);
    localparam int TW = $clog2(MAX_GREEN);
    localparam int CW = $clog2(CLEAR_CYCLES + 1);
    localparam logic [TW-1:0] C_TMR_MIN = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] C_TMR_MAX = TW'(MAX_GREEN - 1);
    localparam logic [CW-1:0] C_CLR_LAST = CW'(CLEAR_CYCLES - 1);

    sched_state_t  r_state, w_state_nxt;
    logic [1:0]    r_cur_dir, w_cur_nxt;
    logic [1:0]    r_last_dir, w_last_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [CW-1:0] r_clr_cnt, w_clr_nxt;
    logic [2:0]    r_out_n, r_out_e, r_out_s, r_out_w;

    logic [3:0]    w_req;
    logic          w_center_busy;
    logic          w_others_wait;
    logic          w_pick_valid;
    logic [1:0]    w_pick_dir;
    logic          w_unused_general;

    assign w_req = {bus.sensor_light[SENS_W], bus.sensor_light[SENS_S],
                    bus.sensor_light[SENS_E], bus.sensor_light[SENS_N]};
    assign w_center_busy    = |bus.sensor_light[3:0];
    assign w_others_wait    = |(w_req & ~(4'b0001 << r_cur_dir));
    assign w_unused_general = ^bus.general_sensors;

    light_rr_pick u_pick (
        .req         (w_req),
        .last        (r_last_dir),
        .grant_valid (w_pick_valid),
        .grant_dir   (w_pick_dir)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cur_dir  <= DIR_N;
            r_last_dir <= DIR_W;
            r_timer    <= '0;
            r_clr_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur_dir  <= w_cur_nxt;
            r_last_dir <= w_last_nxt;
            r_timer    <= w_timer_nxt;
            r_clr_cnt  <= w_clr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur_dir;
        w_last_nxt  = r_last_dir;
        w_timer_nxt = r_timer;
        w_clr_nxt   = r_clr_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid && !w_center_busy) begin
                    w_state_nxt = ST_GREEN;
                    w_cur_nxt   = w_pick_dir;
                    w_last_nxt  = w_pick_dir;
                    w_timer_nxt = '0;
                end
            end
            ST_GREEN: begin
                // With nobody else waiting, a saturated grant simply holds.
                if ((r_timer >= C_TMR_MIN && !w_req[r_cur_dir]) ||
                    (r_timer == C_TMR_MAX && w_others_wait)) begin
                    w_state_nxt = ST_CLEAR;
                    w_clr_nxt   = '0;
                end else if (r_timer != C_TMR_MAX) begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            ST_CLEAR: begin
                if (w_center_busy) begin
                    w_clr_nxt = '0;
                end else if (r_clr_cnt == C_CLR_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_clr_nxt = r_clr_cnt + CW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs follow the registered state, adding one cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_n <= LIGHT_STOP;
            r_out_e <= LIGHT_STOP;
            r_out_s <= LIGHT_STOP;
            r_out_w <= LIGHT_STOP;
        end else begin
            r_out_n <= (r_state == ST_GREEN && r_cur_dir == DIR_N) ? LIGHT_GO : LIGHT_STOP;
            r_out_e <= (r_state == ST_GREEN && r_cur_dir == DIR_E) ? LIGHT_GO : LIGHT_STOP;
            r_out_s <= (r_state == ST_GREEN && r_cur_dir == DIR_S) ? LIGHT_GO : LIGHT_STOP;
            r_out_w <= (r_state == ST_GREEN && r_cur_dir == DIR_W) ? LIGHT_GO : LIGHT_STOP;
        end
    end

    assign bus.outN = r_out_n;
    assign bus.outE = r_out_e;
    assign bus.outS = r_out_s;
    assign bus.outW = r_out_w;
endmodule
`default_nettype wire

// File: tb/tb_light_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_light_rr_scheduler
// Purpose  : Directed self-checking bench for light_rr_scheduler.
// Revision : 1.0
// ============================================================================
module tb_light_rr_scheduler;
    localparam logic [11:0] C_ALL_STOP = 12'h000;
    localparam logic [11:0] C_GO_N     = 12'h800;
    localparam logic [11:0] C_GO_E     = 12'h100;
    localparam logic [11:0] C_GO_S     = 12'h020;
    localparam logic [11:0] C_GO_W     = 12'h004;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    light_rr_scheduler_if bus_if ();

    light_rr_scheduler #(
        .MIN_GREEN    (8),
        .MAX_GREEN    (32),
        .CLEAR_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got {N,E,S,W}=%h expected %h", tag, got, exp);
        end
    endtask

    // One comparison per cycle, sampled 1 time unit after the rising edge.
    task automatic expect_for(input string tag, input int n, input logic [11:0] exp);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check(tag, {bus_if.outN, bus_if.outE, bus_if.outS, bus_if.outW}, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus_if.sensor_light    = 8'h00;
        bus_if.general_sensors = 32'hDEAD_BEEF;

        expect_for("reset", 2, C_ALL_STOP);

        // N and E both waiting: N first, revoked at MAX_GREEN, then E.
        rst = 1'b0;
        bus_if.sensor_light = 8'h60;
        expect_for("arm_first",  1, C_ALL_STOP);
        expect_for("go_n_max",  32, C_GO_N);
        expect_for("clear_n_e",  3, C_ALL_STOP);
        expect_for("go_e_first", 1, C_GO_E);

        // All four waiting: rotation continues E -> S -> W -> N.
        bus_if.sensor_light = 8'hF0;
        expect_for("go_e_rot",  31, C_GO_E);
        expect_for("clear_e_s",  3, C_ALL_STOP);
        expect_for("go_s_rot",  32, C_GO_S);
        expect_for("clear_s_w",  3, C_ALL_STOP);
        expect_for("go_w_rot",  32, C_GO_W);
        expect_for("clear_w_n",  3, C_ALL_STOP);
        expect_for("go_n_rot",  32, C_GO_N);

        // Early request drop honours MIN_GREEN; center busy stalls CLEAR.
        rst = 1'b1;
        bus_if.sensor_light = 8'h00;
        expect_for("reset_2", 1, C_ALL_STOP);
        rst = 1'b0;
        bus_if.sensor_light = 8'h40;
        expect_for("arm_min",   1, C_ALL_STOP);
        expect_for("go_n_pre",  2, C_GO_N);
        bus_if.sensor_light = 8'h02;
        expect_for("go_n_min",  6, C_GO_N);
        expect_for("clear_busy", 5, C_ALL_STOP);
        bus_if.sensor_light = 8'h10;
        expect_for("clear_empty", 3, C_ALL_STOP);
        expect_for("go_s_after", 4, C_GO_S);

        // Reset in the middle of a grant, then first grant returns to N.
        rst = 1'b1;
        bus_if.sensor_light = 8'h50;
        expect_for("rst_mid",  2, C_ALL_STOP);
        rst = 1'b0;
        expect_for("arm_rst",  1, C_ALL_STOP);
        expect_for("go_n_rst", 2, C_GO_N);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
